// File: rtl/mem_multiport.sv
// Multi-channel data memory: NRD read channels share NPHY ports via round-robin, plus one write port.
// Latency: grant is combinational, read data and write ack arrive 1 cycle later; no backpressure on writes.
module mem_multiport #(
    parameter int AW    = 14,
    parameter int DW    = 10,
    parameter int DEPTH = 2**AW,
    parameter int NRD   = 4,
    parameter int NPHY  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    output logic              wr_ack,
    input  logic [NRD-1:0]    rd_req,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_gnt,
    output logic [NRD-1:0]    rd_valid,
    output logic [NRD*DW-1:0] rd_data,
    output logic [15:0]       conflict_cnt
);
    localparam int NP = (NPHY > NRD) ? NRD : NPHY;
    localparam int PW = (NRD > 1) ? $clog2(NRD) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] rr_nxt;
    logic [NRD-1:0] gnt;
    logic [AW-1:0] ra [NRD];
    logic [DW-1:0] rdn [NRD];
    int idx;
    int ngnt;
    int nreq;

    // Walk channels in round-robin order; rr_nxt follows the last grant in scan order.
    always_comb begin
        gnt    = '0;
        rr_nxt = rr_ptr;
        idx    = 0;
        ngnt   = 0;
        nreq   = 0;
        for (int k = 0; k < NRD; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NRD) idx = idx - NRD;
            for (int j = 0; j < NRD; j++) begin
                if (j == idx && rd_req[j] && ngnt < NP && !rst) begin
                    gnt[j] = 1'b1;
                    ngnt   = ngnt + 1;
                    rr_nxt = (j == NRD - 1) ? '0 : PW'(j + 1);
                end
            end
            if (rd_req[k]) nreq = nreq + 1;
        end
    end

    assign rd_gnt = gnt;

    // Out-of-range reads return zero; same-cycle write to the address wins.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            ra[i] = rd_addr[i*AW +: AW];
            if (32'(ra[i]) >= DEPTH)
                rdn[i] = '0;
            else if (wr_req && wr_addr == ra[i])
                rdn[i] = wr_data;
            else
                rdn[i] = mem[ra[i][IW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_req && 32'(wr_addr) < DEPTH)
            mem[wr_addr[IW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid     <= '0;
            rd_data      <= '0;
            wr_ack       <= 1'b0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            rd_valid <= gnt;
            wr_ack   <= wr_req;
            rr_ptr   <= rr_nxt;
            for (int i = 0; i < NRD; i++) begin
                if (gnt[i]) rd_data[i*DW +: DW] <= rdn[i];
            end
            if (nreq > NPHY && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_multiport.sv
// Directed vector bench for mem_multiport: full-depth instance plus a DEPTH=1000 instance.
module tb_mem_multiport;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_req, wr_ack;
    logic [13:0] wr_addr;
    logic [9:0]  wr_data;
    logic [3:0]  rd_req, rd_gnt, rd_valid;
    logic [55:0] rd_addr;
    logic [39:0] rd_data;
    logic [15:0] conflict_cnt;

    logic        w1_req, w1_ack;
    logic [13:0] w1_addr;
    logic [9:0]  w1_data;
    logic [3:0]  r1_req, r1_gnt, r1_valid;
    logic [55:0] r1_addr;
    logic [39:0] r1_data;
    logic [15:0] c1_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_multiport u0 (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .conflict_cnt(conflict_cnt)
    );

    mem_multiport #(.DEPTH(1000)) u1 (
        .clk(clk), .rst(rst), .wr_req(w1_req), .wr_addr(w1_addr), .wr_data(w1_data),
        .wr_ack(w1_ack), .rd_req(r1_req), .rd_addr(r1_addr), .rd_gnt(r1_gnt),
        .rd_valid(r1_valid), .rd_data(r1_data), .conflict_cnt(c1_cnt)
    );

    typedef struct {
        logic [3:0]  req;
        logic [55:0] addr;
        logic        wr;
        logic [13:0] waddr;
        logic [9:0]  wdata;
        logic [3:0]  egnt;
        logic [3:0]  evld;
        logic [39:0] edata;
        logic        eack;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic [13:0] a3, a2, a1, a0,
                       input logic wr, input logic [13:0] wa, input logic [9:0] wd,
                       input logic [3:0] egnt, evld, input logic [9:0] d3, d2, d1, d0,
                       input logic eack, input logic [15:0] ecnt);
        vec_t v;
        v.req = req; v.addr = {a3, a2, a1, a0}; v.wr = wr; v.waddr = wa; v.wdata = wd;
        v.egnt = egnt; v.evld = evld; v.edata = {d3, d2, d1, d0}; v.eack = eack; v.ecnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wr_req = 0; wr_addr = 0; wr_data = 0; rd_req = 0; rd_addr = 0;
        w1_req = 0; w1_addr = 0; w1_data = 0; r1_req = 0; r1_addr = 0;

        add(4'b0001, 0, 0, 0, 14'h0005, 1, 14'h0005, 10'h2A5, 4'b0001, 4'b0001, 0, 0, 0, 10'h2A5, 1, 0);
        add(4'b0000, 0, 0, 0, 0, 1, 14'h0100, 10'h001, 4'b0000, 4'b0000, 0, 0, 0, 10'h2A5, 1, 0);
        add(4'b1000, 14'h0005, 0, 0, 0, 0, 0, 0, 4'b1000, 4'b1000, 10'h2A5, 0, 0, 10'h2A5, 0, 0);
        add(4'b1111, 14'h0005, 14'h0100, 14'h0005, 14'h0100, 1, 14'h0300, 10'h0C3,
            4'b0011, 4'b0011, 10'h2A5, 0, 10'h2A5, 10'h001, 1, 1);
        add(4'b1111, 14'h0005, 14'h0100, 14'h0005, 14'h0100, 1, 14'h0100, 10'h3FF,
            4'b1100, 4'b1100, 10'h2A5, 10'h3FF, 10'h2A5, 10'h001, 1, 2);
        add(4'b1111, 14'h0005, 14'h0100, 14'h0300, 14'h0100, 0, 0, 0,
            4'b0011, 4'b0011, 10'h2A5, 10'h3FF, 10'h0C3, 10'h3FF, 0, 3);
        add(4'b0110, 0, 14'h0300, 14'h0005, 0, 0, 0, 0,
            4'b0110, 4'b0110, 10'h2A5, 10'h0C3, 10'h2A5, 10'h3FF, 0, 3);
        add(4'b0111, 0, 14'h0100, 0, 14'h0005, 0, 0, 0,
            4'b0101, 4'b0101, 10'h2A5, 10'h3FF, 10'h2A5, 10'h2A5, 0, 4);
        add(4'b0011, 0, 0, 14'h0300, 14'h0300, 0, 0, 0,
            4'b0011, 4'b0011, 10'h2A5, 10'h3FF, 10'h0C3, 10'h0C3, 0, 4);

        // Requests during reset must not be granted.
        rd_req = 4'b1111;
        #2;
        chk("rst_gnt", 64'(rd_gnt), 0);
        tick; tick;
        chk("rst_valid", 64'(rd_valid), 0);
        chk("rst_data", 64'(rd_data), 0);
        chk("rst_ack", 64'(wr_ack), 0);
        chk("rst_cnt", 64'(conflict_cnt), 0);
        rst = 1'b0;
        rd_req = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            rd_req = tbl[i].req; rd_addr = tbl[i].addr;
            wr_req = tbl[i].wr; wr_addr = tbl[i].waddr; wr_data = tbl[i].wdata;
            #1;
            chk($sformatf("v%0d_gnt", i), 64'(rd_gnt), 64'(tbl[i].egnt));
            tick;
            chk($sformatf("v%0d_valid", i), 64'(rd_valid), 64'(tbl[i].evld));
            chk($sformatf("v%0d_data", i), 64'(rd_data), 64'(tbl[i].edata));
            chk($sformatf("v%0d_ack", i), 64'(wr_ack), 64'(tbl[i].eack));
            chk($sformatf("v%0d_cnt", i), 64'(conflict_cnt), 64'(tbl[i].ecnt));
        end
        wr_req = 0;

        // Saturation of the conflict counter.
        rd_req = 4'b1111;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_cnt", 64'(conflict_cnt), 64'h FFFF);
        tick;
        chk("sat_hold", 64'(conflict_cnt), 64'h FFFF);

        // Reset pulse with a write that must be ignored.
        rst = 1'b1; wr_req = 1; wr_addr = 14'h0005; wr_data = 10'h111;
        #1;
        chk("rst2_gnt", 64'(rd_gnt), 0);
        tick;
        rst = 1'b0; wr_req = 0; rd_req = 4'b0000;
        chk("rst2_cnt", 64'(conflict_cnt), 0);
        chk("rst2_valid", 64'(rd_valid), 0);
        chk("rst2_ack", 64'(wr_ack), 0);
        chk("rst2_data", 64'(rd_data), 0);
        rd_req = 4'b0001; rd_addr = {14'h0, 14'h0, 14'h0, 14'h0005};
        #1;
        chk("post_gnt", 64'(rd_gnt), 64'h1);
        tick;
        rd_req = 0;
        chk("post_valid", 64'(rd_valid), 64'h1);
        chk("post_data", 64'(rd_data[9:0]), 64'h2A5);

        // DEPTH=1000 instance: out-of-range behaviour.
        r1_req = 4'b0001; r1_addr = {14'h0, 14'h0, 14'h0, 14'h03E8};
        #1;
        chk("oor_gnt", 64'(r1_gnt), 64'h1);
        tick;
        r1_req = 0;
        chk("oor_valid", 64'(r1_valid), 64'h1);
        chk("oor_data", 64'(r1_data), 0);
        w1_req = 1; w1_addr = 14'h03E8; w1_data = 10'h3FF;
        tick;
        chk("oor_wack", 64'(w1_ack), 64'h1);
        w1_addr = 14'h03E7; w1_data = 10'h123;
        r1_req = 4'b0001; r1_addr = {14'h0, 14'h0, 14'h0, 14'h03E8};
        tick;
        w1_req = 0;
        chk("oor_rd2", 64'(r1_data), 0);
        chk("oor_wack2", 64'(w1_ack), 64'h1);
        r1_req = 4'b0010; r1_addr = {14'h0, 14'h0, 14'h03E7, 14'h0};
        tick;
        chk("inr_data", 64'(r1_data), 64'({10'h0, 10'h0, 10'h123, 10'h0}));
        r1_addr = {14'h0, 14'h0, 14'h03E8, 14'h0};
        tick;
        r1_req = 0;
        chk("oor_rd3", 64'(r1_data), 0);
        chk("oor_valid3", 64'(r1_valid), 64'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
